// File: rtl/toyup_pkg.sv
// Shared types for the toyup serial blocks: PISO state encoding and parity bit count.
// PISO_PARITY_EN adds the PARITY state and one parity bit per frame.
package toyup_pkg;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_t;
`else
  localparam int PARITY_BITS = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_t;
`endif

endpackage

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, LSB first, with optional even parity bit.
// Define PISO_PARITY_EN to append the parity bit after the data bits.
module piso_shift_tx
  import toyup_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] din,
  input  logic              shift_en,
  output logic              sout,
  output logic              sout_valid,
  output logic              sout_last,
  output logic              busy,
  output piso_state_t       state
);

  // Handshake: a word transfers on an edge with load_valid && load_ready;
  // load_valid is ignored while load_ready is low, nothing is queued.

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  piso_state_t       state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sout_q, sout_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              ready_q, ready_d;
`ifdef PISO_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef PISO_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
          // Exit is decided at the last count, so the counter never wraps.
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        if (shift_en) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered.
  always_comb begin
    sout_d  = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    ready_d = (state_d == ST_IDLE);
    case (state_d)
      ST_SHIFT: begin
        sout_d  = sreg_d[0];
        valid_d = 1'b1;
`ifndef PISO_PARITY_EN
        last_d  = (cnt_d == LAST_CNT);
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        sout_d  = par_d;
        valid_d = 1'b1;
        last_d  = 1'b1;
      end
`endif
      default: begin
        sout_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign load_ready = ready_q;
  assign busy       = ~ready_q;
  assign state      = state_q;

endmodule
